// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 keypad scan controller.
//   scan_state_t : debounce FSM states
//   key_t        : 4-bit key code plus a "no key" flag
//   KEY_NONE     : the "no key" marker (code field always 0 so == compares work)
//   COL_DRIVE    : one-cold column drive pattern, indexed by column number
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic       none;
        logic [3:0] code;
    } key_t;

    localparam key_t KEY_NONE = '{none: 1'b1, code: 4'd0};

    // Element [0] is the rightmost entry, so COL_DRIVE[0] = 4'b1110.
    localparam logic [3:0][3:0] COL_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Lowest pressed row in the currently driven column; code = row*4 + col.
    function automatic key_t col_candidate(input logic [3:0] rows, input logic [1:0] col_idx);
        key_t k;
        k = KEY_NONE;
        for (int r = 3; r >= 0; r--) begin
            if (!rows[r]) begin
                k.none = 1'b0;
                k.code = {2'(r), col_idx};
            end
        end
        return k;
    endfunction

    function automatic key_t key_min(input key_t a, input key_t b);
        if (a.none) return b;
        if (b.none) return a;
        return (a.code <= b.code) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// ----------------------------------------------------------------------------
// keypad_col_scanner
// Walks the one-cold column drive, synchronises the rows and reduces each
// full 4-column scan to a single key (lowest code wins).
//   clk, rst     : clock, async active-low reset
//   row          : raw keypad rows, active-low
//   col          : column drive, active-low one-cold
//   scan_done    : 1 on the col-3 sampling cycle
//   scan_result  : full-scan result, valid while scan_done=1
// ----------------------------------------------------------------------------
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       scan_done,
    output key_t       scan_result
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] settle_cnt;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2;
    key_t          acc;
    key_t          cand;
    key_t          merged;
    logic          sample;

    assign sample      = (settle_cnt == SETTLE_LAST);
    assign cand        = col_candidate(row_s2, col_idx);
    // Column 0 starts a fresh scan, so the stale accumulator is ignored there.
    assign merged      = (col_idx == 2'd0) ? cand : key_min(acc, cand);
    assign scan_done   = sample && (col_idx == 2'd3);
    assign scan_result = merged;
    assign col         = COL_DRIVE[col_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
            col_idx    <= 2'd0;
            row_s1     <= 4'b1111;
            row_s2     <= 4'b1111;
            acc        <= KEY_NONE;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (sample) begin
                settle_cnt <= '0;
                col_idx    <= col_idx + 2'd1;
                acc        <= merged;
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ----------------------------------------------------------------------------
// keypad_scan_ctrl
// 4x4 keypad scanner with whole-matrix debounce and a 1-entry valid/ready
// event register. Optional auto-repeat when KEYPAD_REPEAT_EN is defined.
//   clk, rst   : clock, async active-low reset
//   row / col  : keypad pins (active-low)
//   key_code   : accepted key (row*4+col), stable while key_valid=1
//   key_valid  : event pending; key_ready accepts it
//   key_held   : debounced "some key down"
//   key_ovf    : 1-cycle pulse when an event is dropped
//
// state     | meaning
// IDLE      | no key accepted
// DEB_PRESS | candidate press seen, counting matching scans
// PRESSED   | key accepted and held
// DEB_REL   | held key changed/released, counting matching scans
// ----------------------------------------------------------------------------
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_PERIOD  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       key_ovf
);

    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);

    logic          scan_done;
    key_t          scan_result;
    scan_state_t   state, state_n;
    key_t          cand, cand_n;
    key_t          accepted, accepted_n;
    logic [DW-1:0] cnt, cnt_n, cnt_inc;
    logic          commit;
    key_t          commit_key;
    logic          emit;
    logic          rpt_fire;
    logic          ev_valid;
    logic [3:0]    ev_code;

    keypad_col_scanner #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .scan_done  (scan_done),
        .scan_result(scan_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cand     <= KEY_NONE;
            cnt      <= '0;
            accepted <= KEY_NONE;
        end else begin
            state    <= state_n;
            cand     <= cand_n;
            cnt      <= cnt_n;
            accepted <= accepted_n;
        end
    end

    // commit: the candidate has met the debounce count (or DEBOUNCE_SCANS==1),
    // resolved after the case so every state shares the accept/release path.
    always_comb begin
        state_n    = state;
        cand_n     = cand;
        cnt_n      = cnt;
        accepted_n = accepted;
        commit     = 1'b0;
        commit_key = KEY_NONE;
        cnt_inc    = (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (!scan_result.none) begin
                        cand_n     = scan_result;
                        cnt_n      = DW'(1);
                        state_n    = DEB_PRESS;
                        commit     = (DEBOUNCE_SCANS == 1);
                        commit_key = scan_result;
                    end
                end
                DEB_PRESS: begin
                    if (scan_result == cand) begin
                        cnt_n      = cnt_inc;
                        commit     = (cnt_inc >= DEB_MAX);
                        commit_key = cand;
                    end else if (scan_result.none) begin
                        state_n = IDLE;
                        cand_n  = KEY_NONE;
                        cnt_n   = '0;
                    end else begin
                        cand_n     = scan_result;
                        cnt_n      = DW'(1);
                        commit     = (DEBOUNCE_SCANS == 1);
                        commit_key = scan_result;
                    end
                end
                PRESSED: begin
                    if (scan_result != accepted) begin
                        cand_n     = scan_result;
                        cnt_n      = DW'(1);
                        state_n    = DEB_REL;
                        commit     = (DEBOUNCE_SCANS == 1);
                        commit_key = scan_result;
                    end
                end
                DEB_REL: begin
                    if (scan_result == accepted) begin
                        state_n = PRESSED;
                        cand_n  = KEY_NONE;
                        cnt_n   = '0;
                    end else if (scan_result == cand) begin
                        cnt_n      = cnt_inc;
                        commit     = (cnt_inc >= DEB_MAX);
                        commit_key = cand;
                    end else begin
                        cand_n     = scan_result;
                        cnt_n      = DW'(1);
                        commit     = (DEBOUNCE_SCANS == 1);
                        commit_key = scan_result;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (commit) begin
            cand_n     = KEY_NONE;
            cnt_n      = '0;
            accepted_n = commit_key;
            state_n    = commit_key.none ? IDLE : PRESSED;
        end
    end

    assign emit     = commit && !commit_key.none;
    assign key_held = (state == PRESSED) || (state == DEB_REL);

`ifdef KEYPAD_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt;
    logic          hold_scan;

    // Any scan that is not a steady hold reloads the delay, so the timer
    // restarts on every entry to PRESSED.
    assign hold_scan = scan_done && (state == PRESSED) && (scan_result == accepted);
    assign rpt_fire  = hold_scan && (rpt_cnt <= RW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_cnt <= RW'(REPEAT_DELAY);
        end else if (scan_done) begin
            if (!hold_scan)
                rpt_cnt <= RW'(REPEAT_DELAY);
            else if (rpt_cnt <= RW'(1))
                rpt_cnt <= RW'(REPEAT_PERIOD);
            else
                rpt_cnt <= rpt_cnt - 1'b1;
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rpt_fire   = 1'b0;
`endif

    assign ev_valid = emit | rpt_fire;
    assign ev_code  = emit ? commit_key.code : accepted.code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            key_ovf   <= 1'b0;
        end else begin
            key_ovf <= 1'b0;
            if (ev_valid) begin
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= ev_code;
                end else begin
                    key_ovf <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule
